// File: rtl/pc_sequencer.sv
// pc_sequencer: 8051-style program counter with nested interrupts and byte-serial return-address push/pop.
// Ports: clock/reset (async, active-high); pc_inc, pc_inc_offset, pc_jmp_z, pc_jmp_nz, value_8bit, acc,
//   pc_load, call, ret, reti, target (decoder); instr_boundary, int_en, int_req, int_prio, int_ack, int_id
//   (interrupt controller); push_stack, pop_stack, stack_in, stack_out (internal-RAM stack); busy, count.
// Optional: define PC_TRACE_EN to add trace_valid/trace_from, which flag every non-increment PC change.
module pc_sequencer #(
    parameter int ADDR_W     = 16,
    parameter int NUM_SRC    = 5,
    parameter int VEC_BASE   = 3,
    parameter int VEC_STRIDE = 8,
    parameter int RESET_PC   = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 pc_inc,
    input  logic                 pc_inc_offset,
    input  logic                 pc_jmp_z,
    input  logic                 pc_jmp_nz,
    input  logic [7:0]           value_8bit,
    input  logic [7:0]           acc,
    input  logic                 pc_load,
    input  logic                 call,
    input  logic                 ret,
    input  logic                 reti,
    input  logic [ADDR_W-1:0]    target,
    input  logic                 instr_boundary,
    input  logic                 int_en,
    input  logic [NUM_SRC-1:0]   int_req,
    input  logic [NUM_SRC-1:0]   int_prio,
    input  logic [7:0]           stack_out,
    output logic                 int_ack,
    output logic [(NUM_SRC > 1 ? $clog2(NUM_SRC) : 1)-1:0] int_id,
    output logic                 push_stack,
    output logic                 pop_stack,
    output logic [7:0]           stack_in,
    output logic                 busy,
    output logic [ADDR_W-1:0]    count
`ifdef PC_TRACE_EN
   ,output logic                 trace_valid,
    output logic [ADDR_W-1:0]    trace_from
`endif
);
    localparam int ID_W = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;

    typedef enum logic [2:0] {RUN, PUSH_LO, PUSH_HI, LOAD, POP_HI, POP_LO, POP_DONE} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   count_nxt, dest, dest_nxt, rel;
    logic [1:0]          in_svc, in_svc_nxt;
    logic [7:0]          pop_hi;
    logic                is_reti, is_reti_nxt;
    logic [NUM_SRC-1:0]  hi_ok, lo_ok, pend;
    logic [ID_W-1:0]     sel;
    logic                accept, taken;

    // in_svc[1] = high level in service, in_svc[0] = low level in service
    assign hi_ok      = in_svc[1] ? '0 : int_req & int_prio;
    assign lo_ok      = |in_svc ? '0 : int_req & ~int_prio;
    assign pend       = |hi_ok ? hi_ok : lo_ok;
    assign accept     = int_en && instr_boundary && state == RUN && |pend;
    assign taken      = pc_inc_offset || (pc_jmp_z && acc == 8'd0) || (pc_jmp_nz && acc != 8'd0);
    assign rel        = count + {{(ADDR_W-8){value_8bit[7]}}, value_8bit};
    assign busy       = state != RUN;
    assign push_stack = state == PUSH_LO || state == PUSH_HI;
    assign pop_stack  = state == POP_HI || state == POP_LO;
    // count is frozen during the push states, so it still holds the return address
    assign stack_in   = state == PUSH_LO ? count[7:0] : state == PUSH_HI ? 8'(count >> 8) : 8'd0;

    // lowest pending index wins within the chosen priority level
    always_comb begin
        sel = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--)
            if (pend[i]) sel = ID_W'(i);
    end

    always_comb begin
        state_nxt   = state;
        count_nxt   = count;
        dest_nxt    = dest;
        in_svc_nxt  = in_svc;
        is_reti_nxt = is_reti;
        case (state)
            RUN: begin
                if (accept) begin
                    state_nxt  = PUSH_LO;
                    dest_nxt   = ADDR_W'(VEC_BASE + int'(sel) * VEC_STRIDE);
                    in_svc_nxt = in_svc | (|hi_ok ? 2'b10 : 2'b01);
                end else if (reti || ret) begin
                    state_nxt   = POP_HI;
                    is_reti_nxt = reti;
                end else if (call) begin
                    state_nxt = PUSH_LO;
                    dest_nxt  = target;
                end else if (pc_load)
                    count_nxt = target;
                else if (taken)
                    count_nxt = rel;
                else if (pc_inc)
                    count_nxt = count + ADDR_W'(1);
            end
            PUSH_LO:  state_nxt = PUSH_HI;
            PUSH_HI:  state_nxt = LOAD;
            LOAD: begin
                count_nxt = dest;
                state_nxt = RUN;
            end
            POP_HI:   state_nxt = POP_LO;
            POP_LO:   state_nxt = POP_DONE;
            POP_DONE: begin
                count_nxt = ADDR_W'({pop_hi, stack_out});
                if (is_reti) in_svc_nxt = in_svc[1] ? {1'b0, in_svc[0]} : 2'b00;
                state_nxt = RUN;
            end
            default:  state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= RUN;
            count   <= ADDR_W'(RESET_PC);
            dest    <= '0;
            in_svc  <= '0;
            is_reti <= 1'b0;
            pop_hi  <= '0;
            int_ack <= 1'b0;
            int_id  <= '0;
        end else begin
            state   <= state_nxt;
            count   <= count_nxt;
            dest    <= dest_nxt;
            in_svc  <= in_svc_nxt;
            is_reti <= is_reti_nxt;
            pop_hi  <= state == POP_LO ? stack_out : pop_hi;
            int_ack <= accept;
            int_id  <= accept ? sel : int_id;
        end
    end

`ifdef PC_TRACE_EN
    logic inc_only, moved;
    assign inc_only = state == RUN && !accept && !reti && !ret && !call && !pc_load && !taken && pc_inc;
    assign moved    = count_nxt != count && !inc_only;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            trace_valid <= 1'b0;
            trace_from  <= '0;
        end else begin
            trace_valid <= moved;
            trace_from  <= moved ? count : trace_from;
        end
    end
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed bench for pc_sequencer with a cycle-level reference model and a stack responder.
module tb_pc_sequencer;
    logic        clock = 1'b0, reset = 1'b1;
    logic        pc_inc, pc_inc_offset, pc_jmp_z, pc_jmp_nz, pc_load, call, ret, reti;
    logic [7:0]  value_8bit, acc, stack_out = 8'h00;
    logic [15:0] target;
    logic        instr_boundary, int_en;
    logic [4:0]  int_req, int_prio;
    logic        int_ack, push_stack, pop_stack, busy;
    logic [2:0]  int_id;
    logic [7:0]  stack_in;
    logic [15:0] count;
`ifdef PC_TRACE_EN
    logic        trace_valid;
    logic [15:0] trace_from;
`endif

    pc_sequencer dut (
        .clock(clock), .reset(reset), .pc_inc(pc_inc), .pc_inc_offset(pc_inc_offset),
        .pc_jmp_z(pc_jmp_z), .pc_jmp_nz(pc_jmp_nz), .value_8bit(value_8bit), .acc(acc),
        .pc_load(pc_load), .call(call), .ret(ret), .reti(reti), .target(target),
        .instr_boundary(instr_boundary), .int_en(int_en), .int_req(int_req), .int_prio(int_prio),
        .stack_out(stack_out), .int_ack(int_ack), .int_id(int_id), .push_stack(push_stack),
        .pop_stack(pop_stack), .stack_in(stack_in), .busy(busy), .count(count)
`ifdef PC_TRACE_EN
       ,.trace_valid(trace_valid), .trace_from(trace_from)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stack RAM: pops return forced bytes first when any are queued.
    logic [7:0] mem [256];
    int         sp;
    logic [7:0] force_q [$];

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            sp = 0;
            stack_out <= 8'h00;
        end else if (push_stack) begin
            mem[sp] = stack_in;
            sp = sp + 1;
        end else if (pop_stack) begin
            if (force_q.size() > 0) stack_out <= force_q.pop_front();
            else if (sp > 0) begin
                sp = sp - 1;
                stack_out <= mem[sp];
            end
        end
    end

    // Reference model: m_phase counts cycles into a push or pop sequence (0 = idle).
    logic [15:0] m_pc, m_dest, m_saved, m_tf;
    logic        m_hi, m_lo, m_pop, m_reti, m_ack, m_tv;
    logic [2:0]  m_id;
    logic [7:0]  m_hb;
    int          m_phase;

    function automatic int lowest(input logic [4:0] v);
        for (int i = 0; i < 5; i++) if (v[i]) return i;
        return 0;
    endfunction

    always @(posedge clock or posedge reset) begin : model
        logic [15:0] old;
        logic        inc;
        logic [4:0]  hv, lv;
        if (reset) begin
            m_pc = 0; m_phase = 0; m_hi = 0; m_lo = 0; m_ack = 0; m_id = 0;
            m_tv = 0; m_tf = 0; m_pop = 0; m_saved = 0; m_reti = 0; m_dest = 0; m_hb = 0;
        end else begin
            old = m_pc; inc = 0; m_ack = 0;
            hv = m_hi ? 5'b0 : int_req & int_prio;
            lv = (m_hi || m_lo) ? 5'b0 : int_req & ~int_prio;
            if (m_phase == 0) begin
                if (int_en && instr_boundary && (hv | lv) != 0) begin
                    m_id = 3'(lowest(hv != 0 ? hv : lv));
                    if (hv != 0) m_hi = 1; else m_lo = 1;
                    m_ack = 1; m_dest = 16'(3 + 8 * int'(m_id)); m_saved = m_pc; m_pop = 0; m_phase = 1;
                end else if (reti || ret) begin
                    m_pop = 1; m_reti = reti; m_phase = 1;
                end else if (call) begin
                    m_pop = 0; m_saved = m_pc; m_dest = target; m_phase = 1;
                end else if (pc_load) m_pc = target;
                else if (pc_inc_offset || (pc_jmp_z && acc == 0) || (pc_jmp_nz && acc != 0))
                    m_pc = 16'(int'(m_pc) + int'($signed(value_8bit)));
                else if (pc_inc) begin
                    m_pc = m_pc + 16'd1; inc = 1;
                end
            end else if (m_phase == 3) begin
                if (m_pop) begin
                    m_pc = {m_hb, stack_out};
                    if (m_reti) begin
                        if (m_hi) m_hi = 0; else m_lo = 0;
                    end
                end else m_pc = m_dest;
                m_phase = 0;
            end else begin
                if (m_pop && m_phase == 2) m_hb = stack_out;
                m_phase++;
            end
            m_tv = m_pc != old && !inc;
            if (m_tv) m_tf = old;
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            chk("count", count, m_pc);
            chk("busy", busy, m_phase != 0);
            chk("push_stack", push_stack, !m_pop && (m_phase == 1 || m_phase == 2));
            chk("pop_stack", pop_stack, m_pop && (m_phase == 1 || m_phase == 2));
            chk("stack_in", stack_in, (!m_pop && m_phase == 1) ? m_saved[7:0] :
                                      (!m_pop && m_phase == 2) ? m_saved[15:8] : 8'h00);
            chk("int_ack", int_ack, m_ack);
            chk("int_id", int_id, m_id);
`ifdef PC_TRACE_EN
            chk("trace_valid", trace_valid, m_tv);
            chk("trace_from", trace_from, m_tf);
`endif
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic idle();
        {pc_inc, pc_inc_offset, pc_jmp_z, pc_jmp_nz, pc_load, call, ret, reti} = '0;
    endtask

    int pops;

    initial begin
        idle();
        value_8bit = 0; acc = 0; target = 0; instr_boundary = 0; int_en = 0; int_req = 0; int_prio = 0;
        #12;
        chk("rst count", count, 16'h0000);
        chk("rst busy", busy, 1'b0);
        chk("rst int_ack", int_ack, 1'b0);
        chk("rst int_id", int_id, 3'd0);
        chk("rst push", push_stack, 1'b0);
        chk("rst pop", pop_stack, 1'b0);
        chk("rst stack_in", stack_in, 8'h00);
        @(posedge clock); #1 reset = 0;

        pc_inc = 1; cyc(3); pc_inc = 0;
        chk("inc x3", count, 16'h0003);

        target = 16'h0100; call = 1; cyc(); call = 0;
        cyc();
        #2 reset = 1;
        #1;
        chk("abort count", count, 16'h0000);
        chk("abort push", push_stack, 1'b0);
        chk("abort busy", busy, 1'b0);
        @(posedge clock); #1 reset = 0;

        target = 16'h0010; pc_load = 1; cyc(); pc_load = 0;
        value_8bit = 8'hF0; acc = 8'h00; pc_jmp_z = 1; cyc();
        chk("jz taken", count, 16'h0000);
        acc = 8'h05; cyc(); pc_jmp_z = 0;
        chk("jz not taken", count, 16'h0000);
        value_8bit = 8'h03; pc_jmp_nz = 1; cyc(); pc_jmp_nz = 0;
        chk("jnz taken", count, 16'h0003);
        target = 16'hFFFF; pc_load = 1; cyc(); pc_load = 0;
        value_8bit = 8'h02; pc_inc_offset = 1; cyc(); pc_inc_offset = 0;
        chk("wrap up", count, 16'h0001);
        value_8bit = 8'hFE; pc_inc_offset = 1; pc_inc = 1; cyc(); idle();
        chk("wrap down", count, 16'hFFFF);

        target = 16'h1234; pc_load = 1; cyc(); pc_load = 0;
        int_en = 1; instr_boundary = 1; int_req = 5'b00010; cyc(); int_req = 0;
        chk("ack src1", int_ack, 1'b1);
        chk("id src1", int_id, 3'd1);
        chk("push lo", stack_in, 8'h34);
        cyc();
        chk("push hi", stack_in, 8'h12);
        cyc(2);
        chk("vector 0B", count, 16'h000B);

        reti = 1; cyc(); reti = 0; cyc(3);
        chk("reti restore", count, 16'h1234);

        int_req = 5'b00001; cyc(); int_req = 0; cyc(3);
        chk("vector 03", count, 16'h0003);
        int_req = 5'b01000; int_prio = 5'b01000; cyc();
        chk("id nest", int_id, 3'd3);
        int_req = 0; cyc(3);
        chk("vector 1B", count, 16'h001B);
        int_prio = 0; int_req = 5'b00100; cyc(3);
        chk("low blocked", int_ack, 1'b0);

        force_q = '{8'h00, 8'h45};
        reti = 1; cyc(); reti = 0;
        pops = 0;
        repeat (3) begin
            pops += int'(pop_stack);
            cyc();
        end
        chk("reti forced", count, 16'h0045);
        chk("pop cycles", pops, 2);
        cyc(2);
        chk("low still blocked", int_ack, 1'b0);

        reti = 1; cyc(); reti = 0; cyc(3);
        chk("reti low", count, 16'h0003);
        cyc();
        chk("ack src2", int_ack, 1'b1);
        chk("id src2", int_id, 3'd2);
        int_req = 0; cyc(3);
        chk("vector 13", count, 16'h0013);

        int_en = 0;
        target = 16'h2000; call = 1; pc_inc = 1; cyc(); idle();
        chk("call push lo", stack_in, 8'h13);
        target = 16'h0777; pc_load = 1; cyc(); pc_load = 0;
        chk("call push hi", stack_in, 8'h00);
        cyc(2);
        chk("call dest", count, 16'h2000);
`ifdef PC_TRACE_EN
        chk("trace pulse", trace_valid, 1'b1);
        chk("trace from", trace_from, 16'h0013);
`endif
        ret = 1; cyc(); ret = 0; cyc(3);
        chk("ret restore", count, 16'h0013);
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
